// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the pipelined RV32M multiplier.
//   - Op encodings, matching funct3[1:0] of the RV32M multiply group.
//   - MUL_MAX_STAGES: deepest supported pipeline.
//   - mul_slice_w(): width of each multiplier-operand slice handled by a stage.
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef logic [1:0] mul_op_t;

   localparam mul_op_t MUL_OP_MUL    = 2'b00;
   localparam mul_op_t MUL_OP_MULH   = 2'b01;
   localparam mul_op_t MUL_OP_MULHSU = 2'b10;
   localparam mul_op_t MUL_OP_MULHU  = 2'b11;

   localparam int MUL_MAX_STAGES = 4;

   // ceil(op_w / stages): each stage consumes one slice of this many B bits.
   function automatic int mul_slice_w(input int op_w, input int stages);
      return (op_w + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/mul_stage.sv
// -----------------------------------------------------------------------------
// mul_stage
// One accumulate stage of the pipelined multiplier. Adds A x slice_IDX(B),
// shifted into place, to the incoming partial sum and registers the result
// together with the sideband (valid, op, rd) and the operands the later
// stages still need. All registers hold while stall is high.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   stall            hold every register of this stage
//   vld_in/op_in/rd_in/a_in/b_in/acc_in   values from the previous stage
//   vld_out/op_out/rd_out/a_out/b_out/acc_out   registered values
// -----------------------------------------------------------------------------
module mul_stage
   import mul_pkg::*;
#(
   parameter int IDX     = 0,
   parameter int STAGES  = 3,
   parameter int OP_W    = 33,
   parameter int B_W     = 33,
   parameter int ACC_W   = 66,
   parameter int SLICE_W = 11,
   parameter int TAG_W   = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic                    vld_in,
   input  mul_op_t                 op_in,
   input  logic [TAG_W-1:0]        rd_in,
   input  logic signed [OP_W-1:0]  a_in,
   input  logic [B_W-1:0]          b_in,
   input  logic signed [ACC_W-1:0] acc_in,
   output logic                    vld_out,
   output mul_op_t                 op_out,
   output logic [TAG_W-1:0]        rd_out,
   output logic signed [OP_W-1:0]  a_out,
   output logic [B_W-1:0]          b_out,
   output logic signed [ACC_W-1:0] acc_out
);

   logic [SLICE_W-1:0]      raw;
   logic signed [SLICE_W:0] slice;
   logic signed [ACC_W-1:0] a_wide;
   logic signed [ACC_W-1:0] s_wide;
   logic signed [ACC_W-1:0] pp;

   assign raw = b_in[IDX*SLICE_W +: SLICE_W];

   // Lower slices are plain unsigned digits; only the top slice carries B's
   // sign (B was already sign- or zero-extended to a whole number of slices).
   assign slice = (IDX == STAGES - 1) ? $signed({raw[SLICE_W-1], raw})
                                      : $signed({1'b0, raw});

   assign a_wide = ACC_W'(a_in);
   assign s_wide = ACC_W'(slice);
   assign pp     = (a_wide * s_wide) <<< (IDX * SLICE_W);

   // Stage register boundary
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_out <= 1'b0;
         op_out  <= MUL_OP_MUL;
         rd_out  <= '0;
         a_out   <= '0;
         b_out   <= '0;
         acc_out <= '0;
      end else if (!stall) begin
         vld_out <= vld_in;
         op_out  <= op_in;
         rd_out  <= rd_in;
         a_out   <= a_in;
         b_out   <= b_in;
         acc_out <= acc_in + pp;
      end
   end

endmodule

// File: rtl/pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier
// Pipelined XLEN x XLEN RV32M multiplier sitting beside the EX stage. Accepts
// one op per cycle, accumulates partial products over STAGES register stages
// and returns the selected product half tagged with its destination register.
//
// Build option: MUL_HIGH_EN
//   defined   - MUL, MULH, MULHSU, MULHU; operands extended to XLEN+1 bits,
//               2*XLEN+2 bit accumulator.
//   undefined - op_i ignored, every op is MUL; XLEN-bit accumulator.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall_i           freeze every stage (including the output)
//   flush_i           drop the op presented this cycle
//   in_valid_i, op_i, opA_i, opB_i, rd_i   new multiply
//   out_valid_o, result_o, rd_o            registered result
//   stage_valid_o, stage_rd_o              per-stage valid/rd, bit 0 youngest
//   busy_o            any stage holds a valid op
// -----------------------------------------------------------------------------
module pipelined_multiplier
   import mul_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   input  logic [1:0]              op_i,
   input  logic [XLEN-1:0]         opA_i,
   input  logic [XLEN-1:0]         opB_i,
   input  logic [TAG_W-1:0]        rd_i,
   output logic                    out_valid_o,
   output logic [XLEN-1:0]         result_o,
   output logic [TAG_W-1:0]        rd_o,
   output logic [STAGES-1:0]       stage_valid_o,
   output logic [STAGES*TAG_W-1:0] stage_rd_o,
   output logic                    busy_o
);

`ifdef MUL_HIGH_EN
   localparam int OP_W  = XLEN + 1;
   localparam int ACC_W = 2 * XLEN + 2;
`else
   localparam int OP_W  = XLEN;
   localparam int ACC_W = XLEN;
`endif
   localparam int SLICE_W = mul_slice_w(OP_W, STAGES);
   localparam int B_W     = STAGES * SLICE_W;

   if (STAGES < 1 || STAGES > MUL_MAX_STAGES) begin : g_bad_stages
      $error("pipelined_multiplier: STAGES must be in 1..%0d", MUL_MAX_STAGES);
   end

   // Index k is the input of stage k; index k+1 is its registered output.
   logic                    vld_p [STAGES+1];
   mul_op_t                 op_p  [STAGES+1];
   logic [TAG_W-1:0]        rd_p  [STAGES+1];
   logic signed [OP_W-1:0]  a_p   [STAGES+1];
   logic [B_W-1:0]          b_p   [STAGES+1];
   logic signed [ACC_W-1:0] acc_p [STAGES+1];

`ifdef MUL_HIGH_EN
   logic a_signed;
   logic b_signed;

   assign a_signed = (op_i != MUL_OP_MULHU);
   assign b_signed = (op_i == MUL_OP_MUL) || (op_i == MUL_OP_MULH);
   assign a_p[0]   = $signed({a_signed & opA_i[XLEN-1], opA_i});
   // B is widened to a whole number of slices so the top slice is complete.
   assign b_p[0]   = B_W'($signed({b_signed & opB_i[XLEN-1], opB_i}));
`else
   assign a_p[0]   = $signed(opA_i);
   assign b_p[0]   = B_W'(opB_i);
`endif

   // Stall is not folded in here: a stalled stage 0 simply does not load.
   assign vld_p[0] = in_valid_i && !flush_i;
   assign op_p[0]  = op_i;
   assign rd_p[0]  = rd_i;
   assign acc_p[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      mul_stage #(
         .IDX     (k),
         .STAGES  (STAGES),
         .OP_W    (OP_W),
         .B_W     (B_W),
         .ACC_W   (ACC_W),
         .SLICE_W (SLICE_W),
         .TAG_W   (TAG_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .stall   (stall_i),
         .vld_in  (vld_p[k]),
         .op_in   (op_p[k]),
         .rd_in   (rd_p[k]),
         .a_in    (a_p[k]),
         .b_in    (b_p[k]),
         .acc_in  (acc_p[k]),
         .vld_out (vld_p[k+1]),
         .op_out  (op_p[k+1]),
         .rd_out  (rd_p[k+1]),
         .a_out   (a_p[k+1]),
         .b_out   (b_p[k+1]),
         .acc_out (acc_p[k+1])
      );

      assign stage_valid_o[k]               = vld_p[k+1];
      assign stage_rd_o[k*TAG_W +: TAG_W]   = rd_p[k+1];
   end

   assign out_valid_o = vld_p[STAGES];
   assign rd_o        = rd_p[STAGES];
   assign busy_o      = |stage_valid_o;

`ifdef MUL_HIGH_EN
   assign result_o = (op_p[STAGES] == MUL_OP_MUL) ? acc_p[STAGES][XLEN-1:0]
                                                  : acc_p[STAGES][2*XLEN-1:XLEN];

   // The two guard bits above the 2*XLEN product are never selected.
   logic unused_tail;
   assign unused_tail = ^{acc_p[STAGES][ACC_W-1 -: 2], a_p[STAGES], b_p[STAGES]};
`else
   assign result_o = acc_p[STAGES];

   logic unused_tail;
   assign unused_tail = ^{op_p[STAGES], a_p[STAGES], b_p[STAGES]};
`endif

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, pipelined XLEN×XLEN multiplier that replaces the single-cycle dummy multiplier beside the EX stage of the RISC-V pipeline. It accepts one RV32M multiply per cycle, accumulates partial products across `STAGES` register stages and delivers a registered result tagged with its destination register. It honours the pipeline's stall and flush, and exposes per-stage valid/rd so the hazard unit can detect multiply-use hazards of any depth.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `STAGES`, default 3: pipeline depth and latency, legal range 1..4.
- `TAG_W`, default 5: destination-register tag width.

Ports:
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low; clock `clk`.
- `stall_i` input, 1 bit: freeze all stages; driven by the EX stall (DCACHE stall on a memory op).
- `flush_i` input, 1 bit: kill the op currently presented on the inputs.
- `in_valid_i` input, 1 bit: a multiply is present this cycle.
- `op_i` input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `opA_i` input, XLEN bits: rs1 value, already forwarded.
- `opB_i` input, XLEN bits: rs2 value, already forwarded.
- `rd_i` input, TAG_W bits: destination register.
- `out_valid_o` output, 1 bit: `result_o`/`rd_o` are valid.
- `result_o` output, XLEN bits: product, selected half.
- `rd_o` output, TAG_W bits: tag of the result.
- `stage_valid_o` output, STAGES bits: valid bit of each in-flight stage; bit 0 is the youngest.
- `stage_rd_o` output, STAGES*TAG_W bits: rd of each stage, same order.
- `busy_o` output, 1 bit: OR of `stage_valid_o`.

## Operation
- Capture condition: an op is captured when `in_valid_i && !flush_i && !stall_i`.
- Operand extension: operands are extended to XLEN+1 bits. A is sign-extended for MUL, MULH and MULHSU. B is sign-extended for MUL and MULH only. All other cases are zero-extended.
- Partial products: B is split into `STAGES` slices of ceil((XLEN+1)/STAGES) bits.
  - Stage k adds A × slice_k << (k × slice width) into a 2·XLEN+2-bit signed accumulator.
  - Slices are unsigned except the top slice, which is signed.
- Output selection: the final stage takes bits [XLEN-1:0] for MUL and [2XLEN-1:XLEN] for the other ops.
- Sideband: op, rd and valid travel with the data through every stage.
- Stall: when `stall_i` is high, every stage register holds, including the output. `out_valid_o` stays at its current value and is not re-asserted as a new result.
- Flush: `flush_i` blocks only the op being presented. In-flight ops are older instructions and always complete.
- Stall and flush together: stall has priority. Nothing is captured, nothing advances, and in-flight ops are unaffected.
- Invalid stages: a stage with valid=0 still shifts but must not raise `out_valid_o`.
- Reset:
  - All stage valid bits, `out_valid_o`, `result_o`, `rd_o` and `stage_rd_o` are 0.
  - `busy_o` is 0.
  - Reset mid-operation discards all in-flight ops.

## Timing
- Latency: an op captured at edge t produces `out_valid_o`=1 with its result after edge t+STAGES−1, so it is visible in cycle t+STAGES. Each cycle of `stall_i` adds one cycle.
- Throughput: one op per cycle. Order is preserved and results are never duplicated or dropped.
- `out_valid_o` is a one-cycle pulse per op when the pipeline is not stalled.
- Hazard visibility: `stage_valid_o`/`stage_rd_o` are registered and describe ops captured on earlier edges. The hazard unit compares them against ID rs1/rs2 to stall until the result is forwardable.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `MUL_HIGH_EN` defined:
  - All four ops are supported.
  - The accumulator is 2·XLEN+2 bits.
- `MUL_HIGH_EN` undefined:
  - `op_i` is ignored and every op behaves as MUL.
  - Operands are not extended and the accumulator is XLEN bits, keeping the low product only.
  - `result_o` equals the MUL result for all ops.

## Structure
- Package `mul_pkg`:
  - Op encodings `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU`.
  - `MUL_MAX_STAGES`=4.
  - The slice-width function.
- Sub-module `mul_stage`: one accumulate stage with its data, valid, op and rd registers and hold-on-stall. It is instantiated STAGES times via generate.
- Top level: operand extension, output half select, and the flattening of stage valid/rd.

## Test plan
Parameters for all scenarios: XLEN=32, STAGES=3.
- MUL: opA=7, opB=0xFFFFFFFD (−3), rd=5 at t → `out_valid_o`=1, `result_o`=0xFFFFFFEB, `rd_o`=5 in cycle t+3, and exactly one pulse.
- High ops, issued back to back:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - The three results appear on consecutive cycles t+3..t+5.
- Stall: three ops are issued back to back, then `stall_i` is held for 2 cycles once the first op is in stage 2 → results are delayed 2 cycles, stay in order, and are not duplicated. `stage_valid_o` holds 3'b111 during the stall.
- Flush: `in_valid_i`=1 with `flush_i`=1 while an older op is in flight → the older op completes and the flushed op never produces `out_valid_o`. Repeat with `stall_i`=1: nothing is captured and state is unchanged.
- Reset: `rst_n`=0 for one edge with 2 ops in flight → next cycle `stage_valid_o`=0, `busy_o`=0, and no `out_valid_o` afterwards.
- `MUL_HIGH_EN` undefined: op=MULHU, 0xFFFFFFFF×0xFFFFFFFF → `result_o`=0x00000001.
